cpu_program_loader: RTL and testbench
=====================================

Name: cpu_program_loader

Overview:
- Boot-time front end for the 5-stage RISC-V cpu; sits directly upstream of its external memory ports.
- Consumes a 32-bit valid/ready word stream: instruction header, instruction words, data header, data words as lo/hi pairs.
- Writes instruction memory through addr_ext/wen_ext/wdata_ext and data memory through addr_ext_2/wen_ext_2/wdata_ext_2.
- On a clean load, raises the cpu enable and holds it.

Parameters:
IMEM_WORDS, 512, instruction-memory depth in 32-bit words; maximum legal instruction count
DMEM_WORDS, 1024, data-memory depth in 64-bit words; maximum legal data count

Ports:
clk  input  1  main clock
rst  input  1  synchronous active-high reset
start  input  1  one-cycle pulse; begins a load from IDLE
s_valid  input  1  stream word valid
s_data  input  32  stream word
s_ready  output  1  loader accepts s_data this cycle
addr_ext  output  64  IMEM byte address
wen_ext  output  1  IMEM write enable
wdata_ext  output  32  IMEM write word
addr_ext_2  output  64  DMEM byte address
wen_ext_2  output  1  DMEM write enable
wdata_ext_2  output  64  DMEM write word
cpu_enable  output  1  drives cpu enable
done  output  1  load completed, level
err  output  1  header out of range, level

Behaviour:
- One clock (clk); reset rst is synchronous and active-high.
- Reset: state IDLE, counters 0, every output 0. rst overrides all other inputs in the same edge, including mid-load and RUN. cpu_enable drops on the edge following rst=1.
- States: IDLE, I_HDR, I_LOAD, D_HDR, D_LO, D_HI, RUN, ERR.
- Transfer: a word transfers on a rising edge with s_valid & s_ready.
  - s_ready = 1 in I_HDR, I_LOAD, D_HDR, D_LO, D_HI; 0 otherwise.
  - s_ready is a pure state decode and does not depend on s_valid.
- IDLE:
  - start=1 -> I_HDR.
  - start in any other state is ignored.
- I_HDR: transfer latches N = s_data.
  - N > IMEM_WORDS -> ERR.
  - N = 0 -> D_HDR.
  - Otherwise -> I_LOAD with index i = 0.
- I_LOAD: each transfer registers one IMEM write.
  - Next cycle: wen_ext = 1, addr_ext = 4*i, wdata_ext = s_data.
  - Latency is exactly 1 cycle. wen_ext is a single-cycle pulse per word.
  - After word N-1 -> D_HDR.
- D_HDR: transfer latches M = s_data.
  - M > DMEM_WORDS -> ERR.
  - M = 0 -> RUN.
  - Otherwise -> D_LO with index j = 0.
- D_LO: transfer holds s_data as the low half -> D_HI.
- D_HI: transfer registers one DMEM write.
  - Next cycle: wen_ext_2 = 1, addr_ext_2 = 8*j, wdata_ext_2 = {s_data, lo}.
  - If j = M-1 -> RUN, else j+1 -> D_LO.
- Stream stalls: s_valid=0 in any load state holds state, counters and the lo half; no write is issued.
- Outputs between writes:
  - addr/wdata buses hold their last value.
  - wen_ext / wen_ext_2 are 0 outside the write-pulse cycle.
  - wen_ext and wen_ext_2 are never 1 in the same cycle.
- RUN:
  - done = 1 and cpu_enable = 1, entered on the cycle after the final write pulse (or the M = 0 header).
  - The final DMEM/IMEM pulse completes before cpu_enable rises.
  - Absorbing until rst.
- ERR: err = 1, cpu_enable = 0, s_ready = 0. Absorbing until rst.
- Width rules:
  - Counters are clog2(depth)+1 bits so N = depth fits.
  - Addresses are zero-extended to 64 bits.
  - Header compare is full 32-bit unsigned.
- cpu_enable = 0 in every state except RUN, so the cpu never runs on a partial image.

Decomposition:
- Shared package cpu_loader_pkg: state enum; IMEM_STRIDE = 4, DMEM_STRIDE = 8.
- Single module, no sub-module. The counters and FSM are small, and a split would add only port plumbing.

Test Plan:
- start, then N=3 with words 0x00500093, 0x00A00113, 0x002081B3, then M=0 -> wen_ext pulses at addr 0x0, 0x4, 0x8 with those words; done=cpu_enable=1 one cycle after the third pulse.
- N=0, M=2, words 0x11111111, 0x22222222, 0x33333333, 0x44444444 -> wen_ext_2 at 0x0 data 0x2222222211111111, then at 0x8 data 0x4444444433333333; no wen_ext pulse.
- N=IMEM_WORDS+1 (513) -> err=1 next cycle; s_ready=0; no write enables; cpu_enable stays 0.
- N=2 with s_valid toggled 1,0,0,1 -> exactly two IMEM writes at 0x0 and 0x4; stall cycles produce no wen_ext.
- rst asserted mid-D_HI, then a fresh start with N=1, M=1 -> all outputs 0 after the reset edge; the reload writes IMEM 0x0 and DMEM 0x0 correctly.
- start pulsed again while in RUN -> no state change; cpu_enable stays 1.

Source files
------------

// File: rtl/cpu_loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM states and the
// byte strides of the instruction and data memories.
package cpu_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    I_HDR,
    I_LOAD,
    D_HDR,
    D_LO,
    D_HI,
    RUN,
    ERR
  } loader_state_e;

  localparam int IMEM_STRIDE = 4;
  localparam int DMEM_STRIDE = 8;

endpackage

// File: rtl/cpu_program_loader.sv
// Boot-time loader: streams an instruction image and a data image into the
// cpu's external memory ports, then releases the cpu enable.
module cpu_program_loader
  import cpu_loader_pkg::*;
#(
  parameter int IMEM_WORDS = 512,
  parameter int DMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        s_valid,
  input  logic [31:0] s_data,
  output logic        s_ready,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic [31:0] wdata_ext,
  output logic [63:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic [63:0] wdata_ext_2,
  output logic        cpu_enable,
  output logic        done,
  output logic        err
);

  // One extra bit so a header equal to the full depth still fits.
  localparam int IW = $clog2(IMEM_WORDS) + 1;
  localparam int DW = $clog2(DMEM_WORDS) + 1;

  loader_state_e state_q, state_d;

  logic [IW-1:0] n_q, i_q;
  logic [DW-1:0] m_q, j_q;
  logic [31:0]   lo_q;
  logic          xfer;
  logic          imem_wr;
  logic          dmem_wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_ready = 1'b0;
    imem_wr = 1'b0;
    dmem_wr = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = I_HDR;
      end
      I_HDR: begin
        s_ready = 1'b1;
        if (s_valid) begin
          if (s_data > 32'(IMEM_WORDS)) state_d = ERR;
          else if (s_data == '0)        state_d = D_HDR;
          else                          state_d = I_LOAD;
        end
      end
      I_LOAD: begin
        s_ready = 1'b1;
        if (s_valid) begin
          imem_wr = 1'b1;
          if (i_q == n_q - IW'(1)) state_d = D_HDR;
        end
      end
      D_HDR: begin
        s_ready = 1'b1;
        if (s_valid) begin
          if (s_data > 32'(DMEM_WORDS)) state_d = ERR;
          else if (s_data == '0)        state_d = RUN;
          else                          state_d = D_LO;
        end
      end
      D_LO: begin
        s_ready = 1'b1;
        if (s_valid) state_d = D_HI;
      end
      D_HI: begin
        s_ready = 1'b1;
        if (s_valid) begin
          dmem_wr = 1'b1;
          if (j_q == m_q - DW'(1)) state_d = RUN;
          else                     state_d = D_LO;
        end
      end
      RUN:     state_d = RUN;
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  assign xfer = s_valid & s_ready;

  // Memory writes are registered: each accepted word appears on the bus one
  // cycle later as a single-cycle enable pulse; the buses hold between writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      n_q         <= '0;
      i_q         <= '0;
      m_q         <= '0;
      j_q         <= '0;
      lo_q        <= '0;
      addr_ext    <= '0;
      wen_ext     <= 1'b0;
      wdata_ext   <= '0;
      addr_ext_2  <= '0;
      wen_ext_2   <= 1'b0;
      wdata_ext_2 <= '0;
    end else begin
      wen_ext   <= imem_wr;
      wen_ext_2 <= dmem_wr;
      if (state_q == I_HDR && xfer) begin
        n_q <= s_data[IW-1:0];
        i_q <= '0;
      end
      if (imem_wr) begin
        addr_ext  <= 64'(i_q) * 64'(IMEM_STRIDE);
        wdata_ext <= s_data;
        i_q       <= i_q + IW'(1);
      end
      if (state_q == D_HDR && xfer) begin
        m_q <= s_data[DW-1:0];
        j_q <= '0;
      end
      if (state_q == D_LO && xfer) begin
        lo_q <= s_data;
      end
      if (dmem_wr) begin
        addr_ext_2  <= 64'(j_q) * 64'(DMEM_STRIDE);
        wdata_ext_2 <= {s_data, lo_q};
        j_q         <= j_q + DW'(1);
      end
    end
  end

  // RUN is entered on the edge that also launches the final DMEM pulse, so the
  // enable is held off while that pulse is still on the bus.
  assign cpu_enable = (state_q == RUN) && !wen_ext_2;
  assign done       = cpu_enable;
  assign err        = (state_q == ERR);

endmodule

// File: tb/tb_cpu_program_loader.sv
// Self-checking bench for cpu_program_loader: a word-level model of the load
// image predicts every memory write and status output on every cycle.
module tb_cpu_program_loader;

  localparam int IMEM_WORDS = 512;
  localparam int DMEM_WORDS = 1024;
  localparam int K_NONE = 0;
  localparam int K_IMEM = 1;
  localparam int K_DMEM = 2;
  localparam int CYCLE_BOUND = 20000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_ready;
  logic [63:0] addr_ext;
  logic        wen_ext;
  logic [31:0] wdata_ext;
  logic [63:0] addr_ext_2;
  logic        wen_ext_2;
  logic [63:0] wdata_ext_2;
  logic        cpu_enable;
  logic        done;
  logic        err;

  cpu_program_loader #(
    .IMEM_WORDS(IMEM_WORDS),
    .DMEM_WORDS(DMEM_WORDS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .addr_ext   (addr_ext),
    .wen_ext    (wen_ext),
    .wdata_ext  (wdata_ext),
    .addr_ext_2 (addr_ext_2),
    .wen_ext_2  (wen_ext_2),
    .wdata_ext_2(wdata_ext_2),
    .cpu_enable (cpu_enable),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Load image: one entry per stream word, with the memory write it must cause.
  logic [31:0] prog[$];
  int          act_kind[$];
  logic [63:0] act_addr[$];
  logic [63:0] act_data[$];
  int          err_at   = -1;
  bit          ends_run = 1'b0;

  logic [31:0] ival_q[$];
  logic [31:0] dval_q[$];
  int          valid_pat[$];

  bit          started   = 1'b0;
  bit          err_seen  = 1'b0;
  bit          fin       = 1'b0;
  bit          checking  = 1'b0;
  int          consumed  = 0;
  int          pend_kind = K_NONE;
  logic [63:0] exp_iaddr = '0;
  logic [63:0] exp_idata = '0;
  logic [63:0] exp_daddr = '0;
  logic [63:0] exp_ddata = '0;
  logic        exp_ready;
  logic        exp_run;

  logic [63:0] obs_i_addr[$];
  logic [63:0] obs_i_data[$];
  logic [63:0] obs_d_addr[$];
  logic [63:0] obs_d_data[$];

  assign exp_ready = started && !fin && !err_seen;
  assign exp_run   = fin && (pend_kind == K_NONE);

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic pushWord(input logic [31:0] w, input int k, input logic [63:0] a,
                          input logic [63:0] d);
    prog.push_back(w);
    act_kind.push_back(k);
    act_addr.push_back(a);
    act_data.push_back(d);
  endtask

  task automatic buildProgram(input int unsigned n, input int unsigned m);
    logic [31:0] w, lo, hi;
    prog.delete();
    act_kind.delete();
    act_addr.delete();
    act_data.delete();
    err_at   = -1;
    ends_run = 1'b0;
    pushWord(n, K_NONE, '0, '0);
    if (n > IMEM_WORDS) begin
      err_at = 0;
      return;
    end
    for (int unsigned i = 0; i < n; i++) begin
      w = (i < ival_q.size()) ? ival_q[i] : $urandom;
      pushWord(w, K_IMEM, 64'(i) * 64'd4, {32'h0, w});
    end
    pushWord(m, K_NONE, '0, '0);
    if (m > DMEM_WORDS) begin
      err_at = prog.size() - 1;
      return;
    end
    for (int unsigned j = 0; j < m; j++) begin
      lo = (2 * j < dval_q.size()) ? dval_q[2 * j] : $urandom;
      hi = (2 * j + 1 < dval_q.size()) ? dval_q[2 * j + 1] : $urandom;
      pushWord(lo, K_NONE, '0, '0);
      pushWord(hi, K_DMEM, 64'(j) * 64'd8, {hi, lo});
    end
    ends_run = 1'b1;
  endtask

  // Model: tracks how far through the image the stream has got.
  always @(posedge clk) begin
    if (rst) begin
      started   <= 1'b0;
      err_seen  <= 1'b0;
      fin       <= 1'b0;
      consumed  <= 0;
      pend_kind <= K_NONE;
      exp_iaddr <= '0;
      exp_idata <= '0;
      exp_daddr <= '0;
      exp_ddata <= '0;
      checking  <= 1'b1;
    end else begin
      pend_kind <= K_NONE;
      if (!started && start) begin
        started <= 1'b1;
      end else if (exp_ready && s_valid) begin
        pend_kind <= act_kind[consumed];
        if (act_kind[consumed] == K_IMEM) begin
          exp_iaddr <= act_addr[consumed];
          exp_idata <= act_data[consumed];
        end
        if (act_kind[consumed] == K_DMEM) begin
          exp_daddr <= act_addr[consumed];
          exp_ddata <= act_data[consumed];
        end
        consumed <= consumed + 1;
        if (consumed == err_at) err_seen <= 1'b1;
        if (ends_run && consumed + 1 == prog.size()) fin <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      checkOutput("s_ready", s_ready, exp_ready);
      checkOutput("wen_ext", wen_ext, pend_kind == K_IMEM);
      checkOutput("wen_ext_2", wen_ext_2, pend_kind == K_DMEM);
      checkOutput("addr_ext", addr_ext, exp_iaddr);
      checkOutput("wdata_ext", wdata_ext, exp_idata);
      checkOutput("addr_ext_2", addr_ext_2, exp_daddr);
      checkOutput("wdata_ext_2", wdata_ext_2, exp_ddata);
      checkOutput("cpu_enable", cpu_enable, exp_run);
      checkOutput("done", done, exp_run);
      checkOutput("err", err, err_seen);
      if (wen_ext === 1'b1) begin
        obs_i_addr.push_back(addr_ext);
        obs_i_data.push_back(64'(wdata_ext));
      end
      if (wen_ext_2 === 1'b1) begin
        obs_d_addr.push_back(addr_ext_2);
        obs_d_data.push_back(wdata_ext_2);
      end
    end
  end

  // Called only at negedge times (or time zero).
  task automatic doReset();
    s_valid = 1'b0;
    start   = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic applyStimulus(input int unsigned n, input int unsigned m, input int stop_at);
    int cyc;
    buildProgram(n, m);
    obs_i_addr.delete();
    obs_i_data.delete();
    obs_d_addr.delete();
    obs_d_data.delete();
    start   = 1'b1;
    s_valid = 1'b0;
    cyc     = 0;
    while (!(fin || err_seen) && cyc < CYCLE_BOUND && !(stop_at >= 0 && consumed == stop_at)) begin
      @(negedge clk);
      start  = 1'b0;
      s_data = (consumed < prog.size()) ? prog[consumed] : $urandom;
      if (valid_pat.size() > 0) s_valid = (valid_pat.pop_front() != 0);
      else                      s_valid = ($urandom_range(0, 3) != 0);
      cyc++;
    end
    if (cyc >= CYCLE_BOUND) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL load_timeout: got %0d words consumed, expected %0d", consumed, prog.size());
    end
    if (stop_at < 0) begin
      repeat (3) @(negedge clk);
      s_valid = 1'b0;
    end
  endtask

  initial begin
    doReset();

    $display("[TB] three instruction words, empty data image");
    ival_q = '{32'h00500093, 32'h00A00113, 32'h002081B3};
    applyStimulus(3, 0, -1);
    ival_q.delete();
    checkOutput("sc1_icount", 64'(obs_i_addr.size()), 64'd3);
    checkOutput("sc1_dcount", 64'(obs_d_addr.size()), 64'd0);
    checkOutput("sc1_addr1", obs_i_addr[1], 64'h4);
    checkOutput("sc1_addr2", obs_i_addr[2], 64'h8);
    checkOutput("sc1_data0", obs_i_data[0], 64'h00500093);
    checkOutput("sc1_data2", obs_i_data[2], 64'h002081B3);
    checkOutput("sc1_enable", cpu_enable, 1'b1);

    $display("[TB] start pulsed while running");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("sc6_enable", cpu_enable, 1'b1);
    checkOutput("sc6_ready", s_ready, 1'b0);
    checkOutput("sc6_icount", 64'(obs_i_addr.size()), 64'd3);

    $display("[TB] empty instruction image, two data words");
    doReset();
    dval_q = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    applyStimulus(0, 2, -1);
    dval_q.delete();
    checkOutput("sc2_icount", 64'(obs_i_addr.size()), 64'd0);
    checkOutput("sc2_dcount", 64'(obs_d_addr.size()), 64'd2);
    checkOutput("sc2_data0", obs_d_data[0], 64'h2222222211111111);
    checkOutput("sc2_addr1", obs_d_addr[1], 64'h8);
    checkOutput("sc2_data1", obs_d_data[1], 64'h4444444433333333);

    $display("[TB] oversize instruction header");
    doReset();
    applyStimulus(IMEM_WORDS + 1, 0, -1);
    checkOutput("sc3_err", err, 1'b1);
    checkOutput("sc3_ready", s_ready, 1'b0);
    checkOutput("sc3_enable", cpu_enable, 1'b0);
    checkOutput("sc3_writes", 64'(obs_i_addr.size() + obs_d_addr.size()), 64'd0);

    $display("[TB] stalled instruction stream");
    doReset();
    valid_pat = '{1, 1, 0, 0, 1, 1};
    applyStimulus(2, 0, -1);
    valid_pat.delete();
    checkOutput("sc4_icount", 64'(obs_i_addr.size()), 64'd2);
    checkOutput("sc4_addr0", obs_i_addr[0], 64'h0);
    checkOutput("sc4_addr1", obs_i_addr[1], 64'h4);

    $display("[TB] reset while waiting for a high data half");
    doReset();
    applyStimulus(1, 1, 4);
    doReset();
    checkOutput("sc5_ready", s_ready, 1'b0);
    checkOutput("sc5_wen", wen_ext, 1'b0);
    checkOutput("sc5_wen2", wen_ext_2, 1'b0);
    checkOutput("sc5_addr", addr_ext, 64'h0);
    checkOutput("sc5_wdata", wdata_ext, 64'h0);
    checkOutput("sc5_addr2", addr_ext_2, 64'h0);
    checkOutput("sc5_wdata2", wdata_ext_2, 64'h0);
    checkOutput("sc5_enable", cpu_enable, 1'b0);
    checkOutput("sc5_done", done, 1'b0);
    checkOutput("sc5_err", err, 1'b0);
    applyStimulus(1, 1, -1);
    checkOutput("sc5_icount", 64'(obs_i_addr.size()), 64'd1);
    checkOutput("sc5_dcount", 64'(obs_d_addr.size()), 64'd1);
    checkOutput("sc5_daddr", obs_d_addr[0], 64'h0);
    checkOutput("sc5_reload_enable", cpu_enable, 1'b1);

    $display("[TB] randomized images");
    for (int r = 0; r < 10; r++) begin
      doReset();
      applyStimulus($urandom_range(0, 6), $urandom_range(0, 5), -1);
    end

    $display("[TB] depth boundaries");
    doReset();
    applyStimulus(IMEM_WORDS, 1, -1);
    checkOutput("full_imem_count", 64'(obs_i_addr.size()), 64'd512);
    doReset();
    applyStimulus(0, DMEM_WORDS, -1);
    checkOutput("full_dmem_last", obs_d_addr[1023], 64'h1FF8);
    doReset();
    applyStimulus(1, DMEM_WORDS + 1, -1);
    checkOutput("dmem_over_err", err, 1'b1);
    doReset();
    applyStimulus(32'hFFFF_FFFF, 0, -1);
    checkOutput("hdr_max_err", err, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
